excp_irq_ctrl: RTL and testbench
================================

Name: excp_irq_ctrl

Overview:
Parametrised interrupt controller for the excp unit. It replaces fixed three-source combinational arbitration with N latched channels, per-channel edge/level mode, fixed-priority selection, a registered cause, a request/take/return handshake and WFI wake. It sits between the interrupt sources (after ita arbitration) and the excp top / PC interrupt input.

Parameters:
IRQ_NUM, 8, number of channels (3..32). Ch0=MSI, ch1=MTI, ch2=MEI, ch3+ = local interrupts.
IRQ_EDGE_MASK, 8'b0000_0000, bit i=1 makes channel i edge-triggered (rising); 0 = level.
XLEN, 32, cause width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dbg_mode  in  1  core in debug mode; masks all requests
irq_src  in  IRQ_NUM  raw interrupt lines
irq_en  in  IRQ_NUM  per-channel enable from CSR (mie bits / local enables)
status_mie_r  in  1  global interrupt enable
wfi_flag_r  in  1  core sleeping in WFI
irq_take  in  1  pulse: pipeline accepted the presented request
irq_mret  in  1  pulse: handler returned
irq_pend  out  IRQ_NUM  pending vector (mip view)
irq_req  out  1  request to PC/excp, held until irq_take
irq_cause  out  XLEN  cause of presented request
irq_wake  out  1  WFI wake indication

Behaviour:
- Reset: irq_pend=0, irq_req=0, irq_cause=0, irq_wake=0, FSM=IDLE, edge-detect history=0.
- Pending, edge channel: set on rising edge of irq_src[i]; cleared on the cycle irq_take fires with that channel selected. If a set and a clear coincide, set wins (a new edge is never lost).
- Pending, level channel: irq_pend[i] = registered irq_src[i]; 1-cycle latency; never cleared by take.
- Active vector: act = irq_pend & irq_en. Select the lowest set index: ch0 > ch1 > ch2 > ch3 ...
- Cause: bit XLEN-1=1. Low bits: ch0=3, ch1=7, ch2=11, ch(i>=3)=16+(i-3). Other bits 0.
- FSM:
  - IDLE: when |act & status_mie_r & ~dbg_mode, go to REQ the next cycle, latching irq_cause from the selected channel. irq_req=1 from the same edge.
  - REQ: irq_req=1 and irq_cause frozen even if a higher-priority channel arrives. On irq_take, go to HANDLE with irq_req=0 next cycle. If act drops to 0 (level source deasserted, or enable cleared) before take, drop irq_req and return to IDLE. dbg_mode=1 or status_mie_r=0 also returns to IDLE (withdraw).
  - HANDLE: no new request until irq_mret, which returns to IDLE. A request may be raised the cycle after mret.
- irq_wake (registered) = wfi_flag_r & ~dbg_mode & |act. It ignores status_mie_r and is independent of FSM state.
- irq_take while not in REQ is ignored. irq_take and irq_mret in the same cycle: take is processed if in REQ, mret if in HANDLE.
- Async reset mid-REQ or mid-HANDLE: everything returns to reset values immediately, and pending edges are lost.
- Latency: source rise to irq_req is 2 cycles for level channels (pend register, then FSM) and 2 cycles for edge channels.

Optional Feature:
EXCP_IRQ_SYNC_EN: when defined, irq_src passes through a 2-flop synchroniser per channel (reset 0) before edge detect and pending logic, adding 2 cycles to every latency above. When undefined, irq_src is used directly and must be clk-synchronous.

Decomposition:
- Shared defines file: cause codes (MSI=3, MTI=7, MEI=11, LOCAL_BASE=16), the interrupt flag bit position, XLEN and FSM state encodings (IDLE/REQ/HANDLE).
- Sub-module excp_irq_prio_enc: parametrised combinational lowest-index priority encoder (vector in; valid and index out). Cause mapping stays in the top.

Test Plan:
- Level ch1 high, irq_en=all, mie=1 -> irq_req=1 two cycles later with irq_cause=0x8000_0007. irq_take -> irq_req=0. irq_mret -> with ch1 still high, irq_req=1 again the cycle after.
- Edge ch3 pulses one cycle while in HANDLE -> irq_pend[3]=1 held. After mret -> cause 0x8000_0010. On take, irq_pend[3]=0.
- ch2 and ch0 rise in the same cycle -> cause 0x8000_0003. ch0 rising while in REQ with cause 11 -> cause stays 11 until take.
- mie=0, wfi_flag_r=1, ch2 rises -> irq_wake=1 and irq_req=0. Set dbg_mode=1 -> irq_wake=0.
- In REQ on level ch1, deassert irq_src[1] -> irq_req drops, FSM=IDLE, no take needed. Deassert rst_n mid-HANDLE -> all outputs 0 at once.
- Edge set and take-clear on the same channel in the same cycle -> irq_pend stays 1. With EXCP_IRQ_SYNC_EN defined, latency in case 1 becomes 4 cycles.

Source files
------------

// File: rtl/excp_irq_ctrl_pkg.sv
// excp_irq_ctrl_pkg: shared constants for the excp interrupt controller.
//   - cause codes for the standard sources and base of the local range
//   - interrupt flag bit position inside the cause register
//   - default cause width
//   - FSM state encodings (IDLE / REQ / HANDLE)
//   - irq_code(): channel index -> low cause code
package excp_irq_ctrl_pkg;

    localparam int unsigned CAUSE_XLEN       = 32;
    localparam int unsigned IRQ_FLAG_BIT     = CAUSE_XLEN - 1;

    localparam int unsigned CAUSE_MSI        = 3;
    localparam int unsigned CAUSE_MTI        = 7;
    localparam int unsigned CAUSE_MEI        = 11;
    localparam int unsigned CAUSE_LOCAL_BASE = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HANDLE = 2'd2;

    // Ch0..2 are the standard machine sources; ch3 and up map linearly
    // onto the local interrupt range.
    function automatic logic [7:0] irq_code(input int unsigned idx);
        case (idx)
            0:       irq_code = 8'(CAUSE_MSI);
            1:       irq_code = 8'(CAUSE_MTI);
            2:       irq_code = 8'(CAUSE_MEI);
            default: irq_code = 8'(CAUSE_LOCAL_BASE + idx - 3);
        endcase
    endfunction

endpackage

// File: rtl/excp_irq_ctrl_if.sv
// excp_irq_ctrl_if: signal bundle between the interrupt sources / CSR / pipeline
// and the interrupt controller.
//   master : controller side (drives irq_pend, irq_req, irq_cause, irq_wake)
//   slave  : core side (drives sources, enables, handshake pulses)
interface excp_irq_ctrl_if #(
    parameter int IRQ_NUM = 8,
    parameter int XLEN    = 32
);
    logic               dbg_mode;
    logic [IRQ_NUM-1:0] irq_src;
    logic [IRQ_NUM-1:0] irq_en;
    logic               status_mie_r;
    logic               wfi_flag_r;
    logic               irq_take;
    logic               irq_mret;
    logic [IRQ_NUM-1:0] irq_pend;
    logic               irq_req;
    logic [XLEN-1:0]    irq_cause;
    logic               irq_wake;

    modport master (
        input  dbg_mode, irq_src, irq_en, status_mie_r, wfi_flag_r, irq_take, irq_mret,
        output irq_pend, irq_req, irq_cause, irq_wake
    );

    modport slave (
        output dbg_mode, irq_src, irq_en, status_mie_r, wfi_flag_r, irq_take, irq_mret,
        input  irq_pend, irq_req, irq_cause, irq_wake
    );
endinterface

// File: rtl/excp_irq_prio_enc.sv
// excp_irq_prio_enc: combinational lowest-index priority encoder.
//   vec   in  N   request vector
//   valid out 1   any bit of vec set
//   idx   out IW  index of the lowest set bit (0 when none)
module excp_irq_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);
    // Scanning high to low lets the lowest set index overwrite last.
    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/excp_irq_ctrl.sv
// excp_irq_ctrl: N-channel latched interrupt controller for the excp unit.
// Per-channel edge/level pending, fixed priority (ch0 highest), registered
// cause, request/take/return handshake and WFI wake.
//   clk, rst_n : core clock, async active-low reset
//   bus        : excp_irq_ctrl_if.master (sources, enables, mie, wfi, dbg,
//                take/mret in; pend, req, cause, wake out)
// Optional build macro EXCP_IRQ_SYNC_EN: adds a 2-flop synchroniser on every
// irq_src line (+2 cycles latency); otherwise irq_src must be clk-synchronous.
module excp_irq_ctrl
    import excp_irq_ctrl_pkg::*;
#(
    parameter int                 IRQ_NUM       = 8,
    parameter logic [IRQ_NUM-1:0] IRQ_EDGE_MASK = '0,
    parameter int                 XLEN          = CAUSE_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    excp_irq_ctrl_if.master bus
);
    localparam int IW = $clog2(IRQ_NUM);

    logic [IRQ_NUM-1:0] src_s, src_q, rise, pend_q, pend_clr, act;
    logic               act_vld, gate, take_ok, wake_q;
    logic [IW-1:0]      act_idx, sel_q;
    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    cause_q, cause_nxt;

`ifdef EXCP_IRQ_SYNC_EN
    logic [IRQ_NUM-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = bus.irq_src;
`endif

    assign rise = src_s & ~src_q;
    assign act  = pend_q & bus.irq_en;

    excp_irq_prio_enc #(.N(IRQ_NUM), .IW(IW)) u_prio (
        .vec   (act),
        .valid (act_vld),
        .idx   (act_idx)
    );

    assign gate    = act_vld & bus.status_mie_r & ~bus.dbg_mode;
    assign take_ok = (state_q == ST_REQ) & bus.irq_take;

    // Take clears the channel that was latched on entry to REQ, not whatever
    // is highest now.
    always_comb begin
        pend_clr = '0;
        if (take_ok) pend_clr[sel_q] = 1'b1;
    end

    always_comb begin
        cause_nxt                = '0;
        cause_nxt[XLEN-1]        = 1'b1;
        cause_nxt[7:0]           = irq_code(32'(act_idx));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gate) state_d = ST_REQ;
            // Take beats withdraw: once accepted the pipeline owns it.
            ST_REQ:    if (bus.irq_take) state_d = ST_HANDLE;
                       else if (!act_vld || bus.dbg_mode || !bus.status_mie_r)
                           state_d = ST_IDLE;
            ST_HANDLE: if (bus.irq_mret) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            pend_q  <= '0;
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cause_q <= '0;
            wake_q  <= 1'b0;
        end else begin
            src_q   <= src_s;
            state_q <= state_d;
            wake_q  <= bus.wfi_flag_r & ~bus.dbg_mode & act_vld;
            // Edge: a new rising edge wins over a coincident take-clear.
            for (int i = 0; i < IRQ_NUM; i++)
                pend_q[i] <= IRQ_EDGE_MASK[i] ? (rise[i] | (pend_q[i] & ~pend_clr[i]))
                                              : src_s[i];
            if (state_q == ST_IDLE && gate) begin
                sel_q   <= act_idx;
                cause_q <= cause_nxt;
            end
        end
    end

    assign bus.irq_pend  = pend_q;
    assign bus.irq_req   = (state_q == ST_REQ);
    assign bus.irq_cause = cause_q;
    assign bus.irq_wake  = wake_q;

endmodule

// File: tb/tb_excp_irq_ctrl.sv
module tb_excp_irq_ctrl;
    localparam int NCH = 8;
    localparam logic [NCH-1:0] EMASK = 8'hF8;  // ch0..2 level, ch3..7 edge
`ifdef EXCP_IRQ_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    excp_irq_ctrl_if #(.IRQ_NUM(NCH), .XLEN(32)) bus ();

    excp_irq_ctrl #(.IRQ_NUM(NCH), .IRQ_EDGE_MASK(EMASK), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks whether a request is being presented and whether a handler is
    // running; pending bits follow the edge/level rules directly.
    logic [7:0]  m_pend, m_prev, m_s1, m_s2;
    bit          m_presenting, m_in_handler, m_wake;
    int          m_sel;
    logic [31:0] m_cause;
    logic [31:0] cause_tab [8];

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_presenting = 0; m_in_handler = 0; m_wake = 0; m_sel = 0; m_cause = '0;
    endtask

    task automatic model_step();
        logic [7:0] se, act, np;
        int hi;
        se  = (SD != 0) ? m_s2 : bus.irq_src;
        act = m_pend & bus.irq_en;
        hi  = lowest(act);
        for (int i = 0; i < 8; i++) begin
            if (EMASK[i]) begin
                np[i] = (se[i] && !m_prev[i]) ||
                        (m_pend[i] && !(m_presenting && bus.irq_take && i == m_sel));
            end else begin
                np[i] = se[i];
            end
        end
        m_wake = bus.wfi_flag_r && !bus.dbg_mode && (act != 0);
        if (m_presenting) begin
            if (bus.irq_take) begin
                m_presenting = 0; m_in_handler = 1;
            end else if (act == 0 || bus.dbg_mode || !bus.status_mie_r) begin
                m_presenting = 0;
            end
        end else if (m_in_handler) begin
            if (bus.irq_mret) m_in_handler = 0;
        end else if (act != 0 && bus.status_mie_r && !bus.dbg_mode) begin
            m_presenting = 1; m_sel = hi; m_cause = cause_tab[hi];
        end
        m_pend = np;
        m_prev = se;
        m_s2   = m_s1;
        m_s1   = bus.irq_src;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".req"},   32'(bus.irq_req),  32'(m_presenting));
        check({tag, ".cause"}, bus.irq_cause,     m_cause);
        check({tag, ".pend"},  32'(bus.irq_pend), 32'(m_pend));
        check({tag, ".wake"},  32'(bus.irq_wake), 32'(m_wake));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  src;
        logic        mie, wfi, dbg, take, mret;
        logic        req;
        logic [31:0] cause;
        logic [7:0]  pend;
        logic        wake;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int n;
        cause_tab[0] = 32'h8000_0003; cause_tab[1] = 32'h8000_0007;
        cause_tab[2] = 32'h8000_000B;
        for (int i = 3; i < 8; i++) cause_tab[i] = 32'h8000_0000 | 32'(16 + i - 3);

        //          src    mie wfi dbg tk mr  req cause          pend  wake
        tbl[0]  = '{8'h02, 1, 0, 0, 0, 0,  0, 32'h0,          8'h02, 0};
        tbl[1]  = '{8'h02, 1, 0, 0, 0, 0,  1, 32'h8000_0007,  8'h02, 0};
        tbl[2]  = '{8'h02, 1, 0, 0, 1, 0,  0, 32'h8000_0007,  8'h02, 0};
        tbl[3]  = '{8'h02, 1, 0, 0, 0, 0,  0, 32'h8000_0007,  8'h02, 0};
        tbl[4]  = '{8'h02, 1, 0, 0, 0, 1,  0, 32'h8000_0007,  8'h02, 0};
        tbl[5]  = '{8'h02, 1, 0, 0, 0, 0,  1, 32'h8000_0007,  8'h02, 0};
        tbl[6]  = '{8'h00, 1, 0, 0, 0, 0,  1, 32'h8000_0007,  8'h00, 0};
        tbl[7]  = '{8'h00, 1, 0, 0, 0, 0,  0, 32'h8000_0007,  8'h00, 0};
        tbl[8]  = '{8'h04, 1, 0, 0, 0, 0,  0, 32'h8000_0007,  8'h04, 0};
        tbl[9]  = '{8'h05, 1, 0, 0, 0, 0,  1, 32'h8000_000B,  8'h05, 0};
        tbl[10] = '{8'h05, 1, 0, 0, 0, 0,  1, 32'h8000_000B,  8'h05, 0};
        tbl[11] = '{8'h05, 1, 0, 0, 1, 0,  0, 32'h8000_000B,  8'h05, 0};
        tbl[12] = '{8'h05, 1, 0, 0, 0, 1,  0, 32'h8000_000B,  8'h05, 0};
        tbl[13] = '{8'h05, 1, 0, 0, 0, 0,  1, 32'h8000_0003,  8'h05, 0};
        tbl[14] = '{8'h05, 1, 0, 0, 1, 0,  0, 32'h8000_0003,  8'h05, 0};
        tbl[15] = '{8'h00, 1, 0, 0, 0, 1,  0, 32'h8000_0003,  8'h00, 0};
        tbl[16] = '{8'h00, 1, 0, 0, 0, 0,  0, 32'h8000_0003,  8'h00, 0};
        tbl[17] = '{8'h04, 0, 1, 0, 0, 0,  0, 32'h8000_0003,  8'h04, 0};
        tbl[18] = '{8'h04, 0, 1, 0, 0, 0,  0, 32'h8000_0003,  8'h04, 1};
        tbl[19] = '{8'h04, 0, 1, 1, 0, 0,  0, 32'h8000_0003,  8'h04, 0};
        tbl[20] = '{8'h00, 0, 0, 0, 0, 0,  0, 32'h8000_0003,  8'h00, 0};

        bus.irq_src = '0; bus.irq_en = 8'hFF; bus.status_mie_r = 1'b0;
        bus.wfi_flag_r = 1'b0; bus.dbg_mode = 1'b0;
        bus.irq_take = 1'b0; bus.irq_mret = 1'b0;
        do_reset();

        check("rst.req",   32'(bus.irq_req),  32'h0);
        check("rst.cause", bus.irq_cause,     32'h0);
        check("rst.pend",  32'(bus.irq_pend), 32'h0);
        check("rst.wake",  32'(bus.irq_wake), 32'h0);

        // Source rise to request latency on a level channel.
        bus.status_mie_r = 1'b1; bus.irq_src = 8'h02;
        n = 0;
        do begin
            step(); n++;
        end while (!bus.irq_req && n < 10);
        check("lat.cycles", 32'(n), 32'(2 + SD));
        check("lat.cause",  bus.irq_cause, 32'h8000_0007);
        bus.irq_src = '0; bus.status_mie_r = 1'b0;
        do_reset();

`ifndef EXCP_IRQ_SYNC_EN
        for (int i = 0; i < 21; i++) begin
            bus.irq_src = tbl[i].src; bus.status_mie_r = tbl[i].mie;
            bus.wfi_flag_r = tbl[i].wfi; bus.dbg_mode = tbl[i].dbg;
            bus.irq_take = tbl[i].take; bus.irq_mret = tbl[i].mret;
            step();
            check($sformatf("tbl%0d.req", i),   32'(bus.irq_req),  32'(tbl[i].req));
            check($sformatf("tbl%0d.cause", i), bus.irq_cause,     tbl[i].cause);
            check($sformatf("tbl%0d.pend", i),  32'(bus.irq_pend), 32'(tbl[i].pend));
            check($sformatf("tbl%0d.wake", i),  32'(bus.irq_wake), 32'(tbl[i].wake));
        end
        bus.irq_take = 1'b0; bus.irq_mret = 1'b0;

        // Edge ch3 pulses while a handler runs; serviced after mret.
        bus.status_mie_r = 1'b1; bus.irq_src = 8'h02; step();
        step();
        check("edgeA.req", 32'(bus.irq_req), 32'h1);
        bus.irq_take = 1'b1; step(); bus.irq_take = 1'b0;
        bus.irq_src = 8'h0A; step();
        check("edgeA.set", 32'(bus.irq_pend), 32'h0A);
        bus.irq_src = 8'h02; step();
        bus.irq_src = 8'h00; step();
        check("edgeA.held", 32'(bus.irq_pend), 32'h08);
        check("edgeA.noreq", 32'(bus.irq_req), 32'h0);
        bus.irq_mret = 1'b1; step(); bus.irq_mret = 1'b0; step();
        check("edgeA.req2",  32'(bus.irq_req), 32'h1);
        check("edgeA.cause", bus.irq_cause, 32'h8000_0010);
        bus.irq_take = 1'b1; step(); bus.irq_take = 1'b0;
        check("edgeA.clr", 32'(bus.irq_pend), 32'h00);
        bus.irq_mret = 1'b1; step(); bus.irq_mret = 1'b0;

        // New edge on the same cycle as the take that clears it: set wins.
        bus.irq_src = 8'h08; step();
        bus.irq_src = 8'h00; step();
        check("edgeB.req", 32'(bus.irq_req), 32'h1);
        bus.irq_src = 8'h08; bus.irq_take = 1'b1; step();
        bus.irq_src = 8'h00; bus.irq_take = 1'b0;
        check("edgeB.keep", 32'(bus.irq_pend), 32'h08);
        bus.irq_mret = 1'b1; step(); bus.irq_mret = 1'b0; step();
        check("edgeB.req2",  32'(bus.irq_req), 32'h1);
        check("edgeB.cause", bus.irq_cause, 32'h8000_0010);
        bus.irq_take = 1'b1; step(); bus.irq_take = 1'b0;
        check("edgeB.clr", 32'(bus.irq_pend), 32'h00);
        bus.irq_mret = 1'b1; step(); bus.irq_mret = 1'b0;

        // Async reset in the middle of a handler.
        bus.irq_src = 8'h02; bus.wfi_flag_r = 1'b1; step(); step();
        bus.irq_take = 1'b1; step(); bus.irq_take = 1'b0;
        check("rstH.wake_pre", 32'(bus.irq_wake), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rstH.req",   32'(bus.irq_req),  32'h0);
        check("rstH.cause", bus.irq_cause,     32'h0);
        check("rstH.pend",  32'(bus.irq_pend), 32'h0);
        check("rstH.wake",  32'(bus.irq_wake), 32'h0);
        bus.irq_src = '0; bus.wfi_flag_r = 1'b0;
        do_reset();
`endif

        // Randomised run against the reference model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) bus.irq_src = 8'($urandom);
            bus.irq_en       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            bus.status_mie_r = ($urandom_range(0, 7) != 0);
            bus.dbg_mode     = ($urandom_range(0, 15) == 0);
            bus.wfi_flag_r   = ($urandom_range(0, 3) == 0);
            bus.irq_take     = ($urandom_range(0, 3) == 0);
            bus.irq_mret     = ($urandom_range(0, 4) == 0);
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
